// File: rtl/spi_target_loader.sv
// SPI mode-0 target that streams host bytes into console memory as byte-write strobes,
// with a small command set (write, status readback, clear count) and a completed-load counter.
module spi_target_loader #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        raw_clk,
    input  logic        reset,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data,
    output logic        mem_write,
    output logic        loading,
    output logic [7:0]  load_count
);

    localparam int unsigned LAST = SYNC_STAGES - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_STATUS,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] vld_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;
    logic                   armed_q;

    state_t      state_q;
    logic [6:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [15:0] addr_q;
    logic        wrote_q;
    logic [7:0]  snap_q;
    logic [6:0]  tx_q;
    logic        miso_q;
    logic [15:0] mem_address_q;
    logic [7:0]  mem_data_q;
    logic        mem_write_q;
    logic        loading_q;
    logic [7:0]  load_count_q;

    logic       sclk_s_c;
    logic       cs_s_c;
    logic       mosi_s_c;
    logic       sclk_rise_c;
    logic       sclk_fall_c;
    logic       cs_rise_c;
    logic       cs_fall_c;
    logic [7:0] shift_d;
    logic       byte_done_c;

    assign sclk_s_c    = sclk_sync_q[LAST];
    assign cs_s_c      = cs_sync_q[LAST];
    assign mosi_s_c    = mosi_sync_q[LAST];
    assign sclk_rise_c = sclk_s_c & ~sclk_prev_q;
    assign sclk_fall_c = ~sclk_s_c & sclk_prev_q;
    assign cs_rise_c   = cs_s_c & ~cs_prev_q;
    assign cs_fall_c   = ~cs_s_c & cs_prev_q;
    assign shift_d     = {shift_q, mosi_s_c};
    assign byte_done_c = sclk_rise_c && (bit_cnt_q == 3'd7);

    // Pin synchronizers, previous-value flops for edge detection, and the arming flag.
    // vld_sync_q marks when the cs chain holds real pin samples rather than reset fill,
    // so a cs already low at reset release cannot start a transfer until cs is seen high.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            vld_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            vld_sync_q  <= {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s_c;
            cs_prev_q   <= cs_s_c;
            armed_q     <= armed_q | (cs_s_c & vld_sync_q[LAST]);
        end
    end

    // Command FSM, byte assembly, write strobes, status shift-out and load counter.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            addr_q        <= '0;
            wrote_q       <= 1'b0;
            snap_q        <= '0;
            tx_q          <= '0;
            miso_q        <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_write_q   <= 1'b0;
            loading_q     <= 1'b0;
            load_count_q  <= '0;
        end else begin
            mem_write_q <= 1'b0;
            if (cs_rise_c) begin
                if ((state_q == ST_DATA) && wrote_q) begin
                    load_count_q <= load_count_q + 8'd1;
                end
                wrote_q <= 1'b0;
            end
            if (cs_s_c) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                shift_q   <= '0;
                loading_q <= 1'b0;
                miso_q    <= 1'b0;
            end else if (state_q == ST_IDLE) begin
                if (cs_fall_c && armed_q) begin
                    state_q <= ST_CMD;
                end
            end else begin
                if (sclk_rise_c) begin
                    shift_q   <= shift_d[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                if (byte_done_c) begin
                    case (state_q)
                        ST_CMD: begin
                            case (shift_d)
                                8'h01: begin
                                    state_q   <= ST_ADDR_HI;
                                    loading_q <= 1'b1;
                                end
                                8'h02: begin
                                    state_q <= ST_STATUS;
                                    snap_q  <= load_count_q;
                                    tx_q    <= load_count_q[6:0];
                                    miso_q  <= load_count_q[7];
                                end
                                8'h03: begin
                                    state_q      <= ST_IGNORE;
                                    load_count_q <= '0;
                                end
                                default: state_q <= ST_IGNORE;
                            endcase
                        end
                        ST_ADDR_HI: begin
                            addr_q[15:8] <= shift_d;
                            state_q      <= ST_ADDR_LO;
                        end
                        ST_ADDR_LO: begin
                            addr_q[7:0] <= shift_d;
                            state_q     <= ST_DATA;
                        end
                        ST_DATA: begin
                            mem_write_q   <= 1'b1;
                            mem_data_q    <= shift_d;
                            mem_address_q <= addr_q;
                            addr_q        <= addr_q + 16'd1;
                            wrote_q       <= 1'b1;
                        end
                        default: ;
                    endcase
                end else if (sclk_fall_c && (state_q == ST_STATUS)) begin
                    // A falling edge at a byte boundary reloads the snapshot so it repeats.
                    if (bit_cnt_q == 3'd0) begin
                        tx_q   <= snap_q[6:0];
                        miso_q <= snap_q[7];
                    end else begin
                        tx_q   <= {tx_q[5:0], 1'b0};
                        miso_q <= tx_q[6];
                    end
                end
            end
        end
    end

    assign spi_miso    = miso_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_write   = mem_write_q;
    assign loading     = loading_q;
    assign load_count  = load_count_q;

endmodule

// File: tb/tb_spi_target_loader.sv
// Bench for spi_target_loader: a host model bit-bangs SPI transactions while a
// transaction-level model predicts strobes, MISO bytes, loading and load_count.
module tb_spi_target_loader;

    logic        raw_clk = 1'b0;
    logic        reset;
    logic        spi_sclk;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic [15:0] mem_address;
    logic [7:0]  mem_data;
    logic        mem_write;
    logic        loading;
    logic [7:0]  load_count;

    always #5 raw_clk = ~raw_clk;

    spi_target_loader #(.SYNC_STAGES(2)) dut (
        .raw_clk     (raw_clk),
        .reset       (reset),
        .spi_sclk    (spi_sclk),
        .spi_cs      (spi_cs),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_write   (mem_write),
        .loading     (loading),
        .load_count  (load_count)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    wr_t         exp_q[$];
    wr_t         cmp_w;
    int          load_exp = 2;  // 0/1 expected value, 2 = don't care
    int          strobes  = 0;
    logic [15:0] last_a   = '0;
    logic [7:0]  last_d   = '0;
    logic [7:0]  model_count = '0;
    logic [7:0]  tx_buf [8];
    logic [7:0]  rx_buf [8];
    logic [7:0]  rtmp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge raw_clk);
    endtask

    // Per-cycle checker: every strobe must match the next predicted write; loading is tracked.
    always @(negedge raw_clk) begin
        if (mem_write === 1'b1) begin
            strobes++;
            last_a = mem_address;
            last_d = mem_data;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got addr %0h data %0h expected no strobe",
                         mem_address, mem_data);
            end else begin
                cmp_w = exp_q.pop_front();
                chk("strobe_addr", 32'(mem_address), 32'(cmp_w.a));
                chk("strobe_data", 32'(mem_data), 32'(cmp_w.d));
            end
        end
        if (load_exp != 2) chk("loading", 32'(loading), 32'(load_exp));
    end

    // Host shifts nb bits of b (MSB first) and samples MISO at each rising SCLK.
    task automatic spi_bits(input logic [7:0] b, input int nb, input bit mark_cmd,
                            output logic [7:0] r);
        r = '0;
        for (int i = 0; i < nb; i++) begin
            spi_mosi = b[7-i];
            cyc(8);
            if (mark_cmd && i == 7) load_exp = 2;
            spi_sclk = 1'b1;
            r = {r[6:0], spi_miso};
            cyc(8);
            spi_sclk = 1'b0;
        end
    endtask

    // One cs-framed transaction of n whole bytes from tx_buf plus `extra` bits of tx_buf[n].
    task automatic run_txn(input int n, input int extra);
        logic [7:0]  cmd;
        logic [7:0]  snap;
        logic [15:0] addr;
        logic [7:0]  r;
        wr_t         w;
        cmd  = tx_buf[0];
        snap = model_count;
        if (cmd == 8'h01 && n >= 3) begin
            addr = {tx_buf[1], tx_buf[2]};
            for (int i = 3; i < n; i++) begin
                w.a = addr;
                w.d = tx_buf[i];
                exp_q.push_back(w);
                addr = addr + 16'd1;
            end
        end
        spi_cs = 1'b0;
        cyc(8);
        for (int i = 0; i < n; i++) begin
            spi_bits(tx_buf[i], 8, i == 0, r);
            rx_buf[i] = r;
            if (i == 0) load_exp = (cmd == 8'h01) ? 1 : 0;
        end
        if (extra > 0) spi_bits(tx_buf[n], extra, 1'b0, r);
        cyc(8);
        load_exp = 2;
        spi_cs   = 1'b1;
        cyc(24);
        load_exp = 0;
        if (cmd == 8'h01 && n >= 4) model_count = model_count + 8'd1;
        else if (cmd == 8'h03) model_count = '0;
        chk("missing_strobes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("load_count", 32'(load_count), 32'(model_count));
        for (int i = 0; i < n; i++) begin
            chk("miso_byte", 32'(rx_buf[i]), (i > 0 && cmd == 8'h02) ? 32'(snap) : 32'd0);
        end
    endtask

    task automatic set5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4);
        tx_buf[0] = b0; tx_buf[1] = b1; tx_buf[2] = b2; tx_buf[3] = b3; tx_buf[4] = b4;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        for (int i = 0; i < 8; i++) begin
            tx_buf[i] = '0;
            rx_buf[i] = '0;
        end
        reset    = 1'b1;
        spi_sclk = 1'b0;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        cyc(3);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
        chk("rst_loading", 32'(loading), 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        chk("rst_miso", 32'(spi_miso), 32'd0);
        reset = 1'b0;
        cyc(10);
        load_exp = 0;

        // Basic write of two bytes.
        s0 = strobes;
        set5(8'h01, 8'h12, 8'h34, 8'hAA, 8'h55);
        run_txn(5, 0);
        chk("t1_strobe_count", 32'(strobes - s0), 32'd2);
        chk("t1_last_addr", 32'(last_a), 32'h1235);
        chk("t1_last_data", 32'(last_d), 32'h55);
        chk("t1_count_lit", 32'(load_count), 32'd1);

        // Address wrap at 0xFFFF.
        set5(8'h01, 8'hFF, 8'hFF, 8'h11, 8'h22);
        run_txn(5, 0);
        chk("t2_last_addr", 32'(last_a), 32'h0000);
        chk("t2_last_data", 32'(last_d), 32'h22);
        chk("t2_count_lit", 32'(load_count), 32'd2);

        // Status readback repeats the count.
        set5(8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
        run_txn(3, 0);
        chk("t3_miso1_lit", 32'(rx_buf[1]), 32'h02);
        chk("t3_miso2_lit", 32'(rx_buf[2]), 32'h02);
        chk("t3_count_lit", 32'(load_count), 32'd2);

        // Partial data byte: no strobe, count unchanged.
        s0 = strobes;
        set5(8'h01, 8'h00, 8'h10, 8'hA5, 8'h00);
        run_txn(3, 5);
        chk("t4_no_strobe", 32'(strobes - s0), 32'd0);
        chk("t4_count_lit", 32'(load_count), 32'd2);

        // Reset in the middle of a data byte; the rest of that transfer is ignored.
        s0 = strobes;
        spi_cs = 1'b0;
        cyc(8);
        spi_bits(8'h01, 8, 1'b1, rtmp);
        load_exp = 1;
        spi_bits(8'h00, 8, 1'b0, rtmp);
        spi_bits(8'h00, 8, 1'b0, rtmp);
        spi_bits(8'hC3, 4, 1'b0, rtmp);
        load_exp = 2;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        load_exp = 0;
        spi_bits(8'h30, 4, 1'b0, rtmp);
        spi_bits(8'h99, 8, 1'b0, rtmp);
        cyc(8);
        spi_cs = 1'b1;
        cyc(24);
        model_count = '0;
        chk("t5_no_strobe", 32'(strobes - s0), 32'd0);
        chk("t5_count_after_reset", 32'(load_count), 32'd0);
        set5(8'h01, 8'h00, 8'h00, 8'h77, 8'h00);
        run_txn(4, 0);
        chk("t5_addr_lit", 32'(last_a), 32'h0000);
        chk("t5_data_lit", 32'(last_d), 32'h77);
        chk("t5_count_lit", 32'(load_count), 32'd1);

        // Raise count to 5, then clear it.
        for (int k = 0; k < 4; k++) begin
            set5(8'h01, 8'h20, 8'(k), 8'(8'h40 + k), 8'h00);
            run_txn(4, 0);
        end
        chk("t6_count5_lit", 32'(load_count), 32'd5);
        set5(8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
        run_txn(1, 0);
        chk("t6_clear_lit", 32'(load_count), 32'd0);

        // Unknown command: bytes ignored, MISO stays 0.
        s0 = strobes;
        set5(8'h7F, 8'hFF, 8'h01, 8'h80, 8'h00);
        run_txn(4, 0);
        chk("t7_no_strobe", 32'(strobes - s0), 32'd0);
        chk("t7_count_lit", 32'(load_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
